mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
- Arbitrates the single-port instruction/data RAM between three requesters: m0 = core load/store unit, m1 = core instruction fetch, m2 = external program loader.
- Sits between the core and the RAM inside the SoC.
- Issues at most one RAM command per cycle and returns read data or a write acknowledge one cycle later to the owning master.
- Supports starvation protection and locked (atomic) sequences, and drives a fetch-stall flag to the core.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width; the strobe width is DATA_WIDTH/8.
- STARVE_LIMIT, 8, number of consecutive denied cycles after which a pending master is force-granted (range 1..255).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- m_req_i  in  3  per-master request; bit k belongs to master k.
- m_we_i  in  3  per-master write enable.
- m_lock_i  in  3  per-master lock; holds ownership after the current grant.
- m_addr_i  in  3*ADDR_WIDTH  per-master address; master k occupies slice [k*ADDR_WIDTH +: ADDR_WIDTH].
- m_wdata_i  in  3*DATA_WIDTH  per-master write data.
- m_wstrb_i  in  3*DATA_WIDTH/8  per-master byte strobes.
- m_gnt_o  out  3  one-hot grant, combinational, same cycle as the request.
- m_rvalid_o  out  3  one-hot response valid, one cycle after the grant.
- m_rdata_o  out  DATA_WIDTH  response data; it is valid for the master whose m_rvalid_o bit is set.
- ram_en_o  out  1  RAM command strobe.
- ram_we_o  out  1  RAM write enable.
- ram_addr_o  out  ADDR_WIDTH  RAM address.
- ram_wdata_o  out  DATA_WIDTH  RAM write data.
- ram_wstrb_o  out  DATA_WIDTH/8  RAM byte strobes.
- ram_rdata_i  in  DATA_WIDTH  RAM read data; fixed 1-cycle latency after ram_en_o.
- hold_flag_o  out  1  fetch stall; equals m_req_i[1] AND NOT m_gnt_o[1].

Behaviour:
- Reset (rst=1 at a clock edge) forces:
  - state=IDLE, owner=0;
  - all starvation counters=0, rr_ptr=0;
  - m_rvalid_o=0, m_rdata_o=0.
  - While rst is high, m_gnt_o=0 and ram_en_o=0 regardless of requests.
- Grant selection (combinational):
  - At most one m_gnt_o bit is set.
  - ram_en_o=|m_gnt_o.
  - ram_we/addr/wdata/wstrb are muxed from the granted master.
  - When no master is granted, the RAM command outputs are 0.
- Priority in default mode is fixed: m0 > m1 > m2.
- Starvation:
  - A per-master 8-bit counter increments each cycle the master has m_req_i=1 and gnt=0, saturating at STARVE_LIMIT.
  - The counter clears when the master is granted or deasserts its request.
  - A master whose counter equals STARVE_LIMIT overrides normal priority.
  - If several masters are starved at once, the lowest index wins.
- Response:
  - Registered.
  - m_rvalid_o[k] is set the cycle after master k is granted, for both reads and writes.
  - m_rdata_o=ram_rdata_i for reads and 0 for writes.
  - Back-to-back grants are permitted in every cycle: full throughput, no bubble.
- FSM states:
  - IDLE: no lock held; normal arbitration.
    - A grant to master k with m_lock_i[k]=1 moves the FSM to LOCKED with owner=k.
  - LOCKED: only the owner may be granted; other masters stay denied and their starvation counters stay frozen (no increment, no clear).
    - The owner is granted whenever it requests.
    - A granted owner request with m_lock_i=0 returns the FSM to IDLE after that access.
    - Owner idle cycles keep the FSM in LOCKED.
- Requests are level-sensitive.
  - A denied master must hold req and its command stable until granted.
  - The arbiter does not buffer requests.
- Reset during an access:
  - The pending response is dropped; m_rvalid_o=0 the next cycle.
  - Any lock is released.
- A request deasserted before grant is simply forgotten.
- Writes with wstrb=0 are still issued and acknowledged.

Optional Feature:
- Macro: MEM_BUS_ARBITER_RR_EN.
- Defined: fixed priority and starvation counters are replaced by round-robin.
  - rr_ptr (2 bits, values 0..2) names the highest-priority master; search order is rr_ptr, rr_ptr+1, rr_ptr+2 mod 3.
  - After any grant to k, rr_ptr becomes (k+1) mod 3.
  - LOCKED behaviour is unchanged, and rr_ptr does not update while LOCKED.
  - STARVE_LIMIT is ignored.
- Undefined: fixed priority with starvation override, as described in Behaviour.

Test Plan:
- Reset, then m1 requests a read of addr 0x10 with RAM[0x10]=0xDEADBEEF -> gnt=3'b010 in the same cycle; next cycle rvalid=3'b010 and rdata=0xDEADBEEF; hold_flag_o=0.
- m0 and m1 request in the same cycle, m0 writes 0x12345678 to 0x20 -> gnt=3'b001 and hold_flag_o=1; next cycle m1 is granted and m0's rvalid fires with rdata=0.
- m0 requests continuously and m2 requests continuously, STARVE_LIMIT=8 -> m2 is denied for 8 cycles and granted on the 9th; its counter returns to 0.
- m2 issues 3 locked writes (lock=1,1,0) while m0 requests throughout -> m0 receives no grant until the cycle after the third m2 grant, and the FSM returns to IDLE.
- rst asserted in the cycle after an m1 read grant -> rvalid=0 and rdata=0; after rst release, m_gnt_o=0 until a request arrives.
- MEM_BUS_ARBITER_RR_EN defined, all three masters requesting continuously -> grant sequence 001, 010, 100, 001 repeating with one response per cycle.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of per-master command inputs, arbiter responses and the RAM command
// port for mem_bus_arbiter. The "slave" modport is the arbiter's view; the
// "master" modport is the surrounding system (core, loader and RAM).
//
// Handshake: m_req_i[k] acts as valid and m_gnt_o[k] as ready. A command is
// transferred in a cycle where both are high. A master that is not granted
// holds req and its command stable until the grant. m_rvalid_o[k] is asserted
// exactly one cycle after the transfer; it has no backpressure.
interface mem_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [2:0]              m_req_i;
    logic [2:0]              m_we_i;
    logic [2:0]              m_lock_i;
    logic [3*ADDR_WIDTH-1:0] m_addr_i;
    logic [3*DATA_WIDTH-1:0] m_wdata_i;
    logic [3*STRB_WIDTH-1:0] m_wstrb_i;
    logic [2:0]              m_gnt_o;
    logic [2:0]              m_rvalid_o;
    logic [DATA_WIDTH-1:0]   m_rdata_o;
    logic                    ram_en_o;
    logic                    ram_we_o;
    logic [ADDR_WIDTH-1:0]   ram_addr_o;
    logic [DATA_WIDTH-1:0]   ram_wdata_o;
    logic [STRB_WIDTH-1:0]   ram_wstrb_o;
    logic [DATA_WIDTH-1:0]   ram_rdata_i;
    logic                    hold_flag_o;

    modport slave (
        input  m_req_i, m_we_i, m_lock_i, m_addr_i, m_wdata_i, m_wstrb_i, ram_rdata_i,
        output m_gnt_o, m_rvalid_o, m_rdata_o, ram_en_o, ram_we_o, ram_addr_o,
        output ram_wdata_o, ram_wstrb_o, hold_flag_o
    );

    modport master (
        output m_req_i, m_we_i, m_lock_i, m_addr_i, m_wdata_i, m_wstrb_i, ram_rdata_i,
        input  m_gnt_o, m_rvalid_o, m_rdata_o, ram_en_o, ram_we_o, ram_addr_o,
        input  ram_wdata_o, ram_wstrb_o, hold_flag_o
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Three-master arbiter for the single-port instruction/data RAM.
// m0 = load/store unit, m1 = instruction fetch, m2 = program loader.
// Grants are combinational, responses return one cycle later. Locked
// sequences keep ownership with one master until it drops m_lock_i.
// Optional macro MEM_BUS_ARBITER_RR_EN replaces fixed priority with
// starvation override by a round-robin pointer.
// dbg_state_o (1 = LOCKED) and dbg_owner_o expose the FSM for observation.
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst,
    mem_bus_arbiter_if.slave    bus,
    output logic                dbg_state_o,
    output logic [1:0]          dbg_owner_o
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            owner_q, owner_d;
    logic [2:0]            rvalid_q, rvalid_d;
    logic                  rd_q, rd_d;

    logic [2:0]            gnt;
    logic                  gnt_any;
    logic [1:0]            gnt_idx;

`ifdef MEM_BUS_ARBITER_RR_EN
    logic [1:0]            rr_ptr_q, rr_ptr_d;
    logic [2:0]            rr_sum;
    logic [1:0]            rr_idx;
    logic                  rr_found;
`else
    localparam logic [7:0] STARVE_CAP = 8'(STARVE_LIMIT);
    logic [7:0]            cnt_q [3];
    logic [7:0]            cnt_d [3];
    logic [2:0]            starved;
`endif

    // Grant selection: lock owner first, then round-robin or starvation/fixed priority
    always_comb begin
        gnt = 3'b000;
`ifdef MEM_BUS_ARBITER_RR_EN
        rr_sum   = 3'd0;
        rr_idx   = 2'd0;
        rr_found = 1'b0;
`else
        starved  = 3'b000;
`endif
        if (!rst) begin
            if (state_q == LOCKED) begin
                if (bus.m_req_i[owner_q]) begin
                    gnt[owner_q] = 1'b1;
                end
            end else begin
`ifdef MEM_BUS_ARBITER_RR_EN
                for (int i = 0; i < 3; i++) begin
                    rr_sum = {1'b0, rr_ptr_q} + 3'(i);
                    if (rr_sum >= 3'd3) begin
                        rr_sum = rr_sum - 3'd3;
                    end
                    rr_idx = rr_sum[1:0];
                    if (!rr_found && bus.m_req_i[rr_idx]) begin
                        gnt[rr_idx] = 1'b1;
                        rr_found    = 1'b1;
                    end
                end
`else
                for (int k = 0; k < 3; k++) begin
                    starved[k] = bus.m_req_i[k] && (cnt_q[k] == STARVE_CAP);
                end
                // Isolate the lowest set bit: starved masters first, else plain requests
                if (|starved) begin
                    gnt = starved & (~starved + 3'd1);
                end else begin
                    gnt = bus.m_req_i & (~bus.m_req_i + 3'd1);
                end
`endif
            end
        end
    end

    // Encode the one-hot grant and mux the winner's command onto the RAM port
    always_comb begin
        gnt_any         = |gnt;
        gnt_idx         = gnt[1] ? 2'd1 : (gnt[2] ? 2'd2 : 2'd0);
        bus.ram_en_o    = gnt_any;
        bus.ram_we_o    = 1'b0;
        bus.ram_addr_o  = '0;
        bus.ram_wdata_o = '0;
        bus.ram_wstrb_o = '0;
        if (gnt_any) begin
            bus.ram_we_o    = bus.m_we_i[gnt_idx];
            bus.ram_addr_o  = bus.m_addr_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            bus.ram_wdata_o = bus.m_wdata_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            bus.ram_wstrb_o = bus.m_wstrb_i[gnt_idx*STRB_WIDTH +: STRB_WIDTH];
        end
    end

    // Lock FSM next state; a granted owner access without lock ends the sequence
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (gnt_any && bus.m_lock_i[gnt_idx]) begin
                    state_d = LOCKED;
                    owner_d = gnt_idx;
                end
            end
            LOCKED: begin
                if (gnt_any && !bus.m_lock_i[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef MEM_BUS_ARBITER_RR_EN
    // Pointer moves past the last winner; frozen while a lock is held
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == IDLE && gnt_any) begin
            rr_ptr_d = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
        end
    end
`else
    // Starvation counters: count denied cycles, clear on grant or request drop;
    // non-owners are frozen while another master holds the lock
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            cnt_d[k] = cnt_q[k];
            if (state_q == LOCKED && owner_q != 2'(k)) begin
                cnt_d[k] = cnt_q[k];
            end else if (!bus.m_req_i[k] || gnt[k]) begin
                cnt_d[k] = 8'd0;
            end else if (cnt_q[k] != STARVE_CAP) begin
                cnt_d[k] = cnt_q[k] + 8'd1;
            end
        end
    end
`endif

    // Response tracking: which master gets rvalid next cycle, and whether it was a read
    always_comb begin
        rvalid_d = gnt;
        rd_d     = gnt_any && !bus.ram_we_o;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= 2'd0;
            rvalid_q <= 3'b000;
            rd_q     <= 1'b0;
`ifdef MEM_BUS_ARBITER_RR_EN
            rr_ptr_q <= 2'd0;
`else
            for (int k = 0; k < 3; k++) begin
                cnt_q[k] <= 8'd0;
            end
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rvalid_q <= rvalid_d;
            rd_q     <= rd_d;
`ifdef MEM_BUS_ARBITER_RR_EN
            rr_ptr_q <= rr_ptr_d;
`else
            for (int k = 0; k < 3; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
`endif
        end
    end

    // Outputs: RAM read data passes through only for a read response; writes return 0
    always_comb begin
        bus.m_gnt_o     = gnt;
        bus.m_rvalid_o  = rvalid_q;
        bus.m_rdata_o   = rd_q ? bus.ram_rdata_i : '0;
        bus.hold_flag_o = bus.m_req_i[1] & ~gnt[1];
        dbg_state_o     = state_q;
        dbg_owner_o     = owner_q;
    end
endmodule
